// File: rtl/fetch_unit.sv
// Purpose: sequential instruction fetch ahead of the icache, buffering returned words for decode.
// Latency: ic_en in cycle N -> word in FIFO at end of N+1 -> dec_valid in N+2; redirect takes effect next cycle.
// Backpressure: issue is credit-limited by (buffered + in-flight) < FIFO_DEPTH, so a response always has room.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [29:0] ic_index,
    output logic        ic_en,
    input  logic [31:0] ic_rdata,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr,
    input  logic        dec_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    // PCs are always word aligned, so only the word index is stored.
    logic [29:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [29:0]   issued_pc_q, issued_pc_d;

    logic [29:0]   fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]   fifo_instr_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [CW:0]   occupancy;
    logic          credit_ok;
    logic          push;
    logic          pop;

    // Low two bits of the redirect target are architecturally ignored.
    logic          unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credits come from the registered count only, so dec_ready never reaches ic_en.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign credit_ok = (occupancy < DEPTH_C);
    assign ic_en     = !rst && !redirect_valid && credit_ok;
    assign ic_index  = pc_q;

    // A response is captured the cycle after its issue unless a redirect squashes it.
    assign push = inflight_q && !redirect_valid;

    // Redirect flushes the buffer, so a same-cycle dec_ready must not pop anything.
    assign pop  = dec_valid && dec_ready && !redirect_valid;

    assign dec_valid = (count_q != '0);
    assign dec_pc    = dec_valid ? {fifo_pc_q[rd_ptr_q], 2'b00} : 32'h0;
    assign dec_instr = dec_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;

    // Next PC, in-flight tracking and issued-PC capture.
    always_comb begin
        pc_d        = pc_q;
        inflight_d  = ic_en;
        issued_pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc[31:2];
        end else if (ic_en) begin
            pc_d = pc_q + 30'd1;
        end
    end

    // Buffer pointer and occupancy update; a flush rewinds both pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state; reset drops any outstanding read and empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC[31:2];
            inflight_q  <= 1'b0;
            issued_pc_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            pc_q        <= pc_d;
            inflight_q  <= inflight_d;
            issued_pc_q <= issued_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Buffer storage; contents are only observable through count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= issued_pc_q;
            fifo_instr_q[wr_ptr_q] <= ic_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int DEPTH = 4;
    localparam logic [31:0] KEY = 32'h5A5A_0F0F;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [29:0] ic_index;
    logic        ic_en;
    logic [31:0] ic_rdata;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        dec_ready;

    fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ic_index(ic_index), .ic_en(ic_en), .ic_rdata(ic_rdata),
        .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_instr(dec_instr),
        .dec_ready(dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // The instruction word the icache holds at a given byte address.
    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return addr ^ KEY;
    endfunction

    // Icache: data for a read appears one cycle after ic_en; garbage otherwise.
    logic        ic_en_s;
    logic [29:0] ic_idx_s;
    initial ic_rdata = 32'h0;
    always begin
        @(negedge clk);
        ic_en_s  = ic_en;
        ic_idx_s = ic_index;
        @(posedge clk);
        #1;
        ic_rdata = ic_en_s ? word_at({ic_idx_s, 2'b00}) : $urandom;
    end

    // Reference model: next fetch address, one optional outstanding read, and a queue of buffered words.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_infl;
    logic [31:0] m_infl_pc;
    logic        e_en;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] acc[$];
    int          cyc;
    logic        obs_en    [64];
    logic        obs_valid [64];
    logic [31:0] obs_pc    [64];
    logic [31:0] obs_instr [64];
    logic [31:0] obs_index [64];

    initial begin
        m_pc = 32'h0; m_infl = 1'b0; m_infl_pc = 32'h0; cyc = 0;
    end

    // Compare outputs against the model every cycle, then advance the model across the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ic_en", {31'b0, ic_en}, 32'h0);
            chk("rst_dec_valid", {31'b0, dec_valid}, 32'h0);
            chk("rst_dec_pc", dec_pc, 32'h0);
            chk("rst_dec_instr", dec_instr, 32'h0);
            chk("rst_ic_index", {2'b0, ic_index}, 32'h0);
            mq.delete();
            acc.delete();
            m_pc = 32'h0; m_infl = 1'b0; cyc = 0;
        end else begin
            e_en    = !redirect_valid && ((mq.size() + (m_infl ? 1 : 0)) < DEPTH);
            e_valid = (mq.size() != 0);
            e_pc    = e_valid ? mq[0].pc : 32'h0;
            e_instr = e_valid ? mq[0].instr : 32'h0;
            chk("ic_en", {31'b0, ic_en}, {31'b0, e_en});
            chk("ic_index", {2'b0, ic_index}, {2'b0, m_pc[31:2]});
            chk("dec_valid", {31'b0, dec_valid}, {31'b0, e_valid});
            chk("dec_pc", dec_pc, e_pc);
            chk("dec_instr", dec_instr, e_instr);
            if (cyc < 64) begin
                obs_en[cyc] = ic_en; obs_valid[cyc] = dec_valid;
                obs_pc[cyc] = dec_pc; obs_instr[cyc] = dec_instr;
                obs_index[cyc] = {2'b0, ic_index};
            end
            if (redirect_valid) begin
                mq.delete();
                m_infl = 1'b0;
                m_pc   = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (e_valid && dec_ready) begin
                    acc.push_back(mq[0].pc);
                    void'(mq.pop_front());
                end
                if (m_infl) mq.push_back('{pc: m_infl_pc, instr: word_at(m_infl_pc)});
                m_infl    = e_en;
                m_infl_pc = m_pc;
                if (e_en) m_pc = m_pc + 32'd4;
            end
            cyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] acc_at(input int i);
        return (i < acc.size()) ? acc[i] : 32'hDEAD_BEEF;
    endfunction

    int n_en;

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b1;
        tick(3);

        // Reset stream with decode always ready.
        rst = 1'b0;
        tick(8);
        chk("t1_en_c0", {31'b0, obs_en[0]}, 32'h1);
        chk("t1_valid_c1", {31'b0, obs_valid[1]}, 32'h0);
        chk("t1_valid_c2", {31'b0, obs_valid[2]}, 32'h1);
        chk("t1_pc_c2", obs_pc[2], 32'h0);
        chk("t1_instr_c2", obs_instr[2], 32'h5A5A_0F0F);
        chk("t1_pc_c3", obs_pc[3], 32'h4);
        chk("t1_pc_c4", obs_pc[4], 32'h8);
        chk("t1_pc_c5", obs_pc[5], 32'hC);

        // Backpressure from cycle 0: exactly four fetches, head held.
        rst = 1'b1; dec_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(10);
        n_en = 0;
        for (int i = 0; i < 10; i++) n_en += obs_en[i] ? 1 : 0;
        chk("t2_fetch_count", n_en, 4);
        chk("t2_en_c9", {31'b0, obs_en[9]}, 32'h0);
        chk("t2_pc_held", obs_pc[9], 32'h0);
        dec_ready = 1'b1;
        tick(12);
        for (int i = 0; i < 6; i++) chk("t2_order", acc_at(i), 32'(i * 4));

        // Redirect with two buffered words and one read in flight.
        rst = 1'b1; dec_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(3);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick(1);
        redirect_valid = 1'b0;
        #3;
        chk("t3_valid_r1", {31'b0, dec_valid}, 32'h0);
        chk("t3_index_r1", {2'b0, ic_index}, 32'h40);
        dec_ready = 1'b1;
        tick(6);
        chk("t3_first", acc_at(0), 32'h100);
        chk("t3_second", acc_at(1), 32'h104);

        // Misaligned target.
        redirect_valid = 1'b1; redirect_pc = 32'h203; acc.delete();
        tick(1);
        redirect_valid = 1'b0;
        tick(5);
        chk("t4_misaligned", acc_at(0), 32'h200);
        chk("t4_misaligned_next", acc_at(1), 32'h204);

        // Back-to-back redirects: the later one wins.
        redirect_valid = 1'b1; redirect_pc = 32'h10; acc.delete();
        tick(1);
        redirect_pc = 32'h20;
        tick(1);
        redirect_valid = 1'b0;
        #3;
        chk("t4_b2b_index", {2'b0, ic_index}, 32'h8);
        tick(5);
        chk("t4_b2b_first", acc_at(0), 32'h20);

        // Address wrap.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; acc.delete();
        tick(1);
        redirect_valid = 1'b0;
        tick(7);
        chk("t5_wrap0", acc_at(0), 32'hFFFF_FFF8);
        chk("t5_wrap1", acc_at(1), 32'hFFFF_FFFC);
        chk("t5_wrap2", acc_at(2), 32'h0000_0000);
        chk("t5_wrap3", acc_at(3), 32'h0000_0004);

        // Asynchronous reset with three buffered words and a read in flight.
        rst = 1'b1; dec_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(4);
        chk("t6_pre_valid", {31'b0, dec_valid}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_ic_en", {31'b0, ic_en}, 32'h0);
        chk("t6_dec_valid", {31'b0, dec_valid}, 32'h0);
        chk("t6_dec_pc", dec_pc, 32'h0);
        chk("t6_dec_instr", dec_instr, 32'h0);
        chk("t6_ic_index", {2'b0, ic_index}, 32'h0);
        tick(2);
        dec_ready = 1'b1;
        rst = 1'b0;
        tick(8);
        chk("t6_first", acc_at(0), 32'h0);
        chk("t6_pc_c2", obs_pc[2], 32'h0);

        // Randomized traffic checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            dec_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                                         : $urandom;
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                tick(2);
                rst = 1'b0;
            end
            tick(1);
        end
        redirect_valid = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
